// File: rtl/lsm_fx_pkg.sv
// lsm_fx_pkg: shared fixed-point definitions for the LSM normal-equation
// accumulator.
//   - Default word, fraction, accumulator and counter widths, and ONE.
//   - state_t: accumulator FSM encoding.
//   - sat_trunc: narrows an accumulator-width value to a word, saturating.
//   - sat_add: saturating accumulator-width add.
//   - sext: sign-extends a word to accumulator width.
package lsm_fx_pkg;

    localparam int FX_WIDTH     = 32;
    localparam int FX_FRAC_BITS = 16;
    localparam int FX_ACC_WIDTH = 64;
    localparam int FX_CNT_WIDTH = 16;

    localparam logic signed [FX_WIDTH-1:0] ONE = FX_WIDTH'(1 << FX_FRAC_BITS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    typedef struct packed {
        logic [FX_WIDTH-1:0] value;
        logic                sat;
    } trunc_t;

    typedef struct packed {
        logic [FX_ACC_WIDTH-1:0] value;
        logic                    sat;
    } acc_t;

    // The value fits in a word only when every bit above the word's sign
    // bit equals that sign bit.
    function automatic trunc_t sat_trunc(input logic signed [FX_ACC_WIDTH-1:0] x);
        trunc_t r;
        logic [FX_ACC_WIDTH-FX_WIDTH:0] top;
        top = x[FX_ACC_WIDTH-1:FX_WIDTH-1];
        if ((top == '0) || (top == '1)) begin
            r.value = x[FX_WIDTH-1:0];
            r.sat   = 1'b0;
        end else begin
            r.sat   = 1'b1;
            r.value = x[FX_ACC_WIDTH-1] ? {1'b1, {(FX_WIDTH-1){1'b0}}}
                                        : {1'b0, {(FX_WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    // Overflow only when both operands share a sign and the sum's sign differs.
    function automatic acc_t sat_add(input logic signed [FX_ACC_WIDTH-1:0] a,
                                     input logic signed [FX_ACC_WIDTH-1:0] b);
        acc_t r;
        logic signed [FX_ACC_WIDTH-1:0] s;
        s = a + b;
        if ((a[FX_ACC_WIDTH-1] == b[FX_ACC_WIDTH-1]) &&
            (s[FX_ACC_WIDTH-1] != a[FX_ACC_WIDTH-1])) begin
            r.sat   = 1'b1;
            r.value = a[FX_ACC_WIDTH-1] ? {1'b1, {(FX_ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(FX_ACC_WIDTH-1){1'b1}}};
        end else begin
            r.sat   = 1'b0;
            r.value = s;
        end
        return r;
    endfunction

    function automatic logic signed [FX_ACC_WIDTH-1:0] sext(input logic [FX_WIDTH-1:0] v);
        return {{(FX_ACC_WIDTH-FX_WIDTH){v[FX_WIDTH-1]}}, v};
    endfunction

endpackage

// File: rtl/fx_mul_sat.sv
// fx_mul_sat: one-cycle registered signed fixed-point multiplier.
// The full double-width product is shifted right arithmetically by FRAC_BITS
// and saturated to WIDTH bits.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   a, b       : signed fixed-point operands
//   p          : registered saturated product
//   sat        : registered, high when p was clipped
module fx_mul_sat
    import lsm_fx_pkg::*;
#(
    parameter int WIDTH     = FX_WIDTH,
    parameter int FRAC_BITS = FX_FRAC_BITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] p,
    output logic                    sat
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shifted;
    trunc_t                    t;

    always_comb begin
        prod    = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        shifted = prod >>> FRAC_BITS;
        t       = sat_trunc(shifted);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p   <= '0;
            sat <= 1'b0;
        end else begin
            p   <= t.value;
            sat <= t.sat;
        end
    end

endmodule

// File: rtl/lsm_normal_eq_accum.sv
// lsm_normal_eq_accum: accumulates the least-squares normal equations for
// basis {1, S, S^2} over one batch of (S, Y) path samples:
//   A = [[n, Ss, Ss2], [Ss, Ss2, Ss3], [Ss2, Ss3, Ss4]], B = [Sy, Ssy, Ss2y].
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : begin a new batch (IDLE only)
//   in_valid/in_ready    : sample handshake; s_in, y_in, in_last
//   out_valid/out_ready  : result handshake; a_flat, b_flat, path_count
//   sat_flag             : sticky saturation indicator for the batch
//   fsm_state            : current FSM state, for observation
// Handshake: a transfer occurs on a rising edge where valid and ready are
// both high. A producer holds its payload stable while valid is high and
// ready is low; valid is never withdrawn before the transfer.
module lsm_normal_eq_accum
    import lsm_fx_pkg::*;
#(
    parameter int WIDTH      = FX_WIDTH,
    parameter int FRAC_BITS  = FX_FRAC_BITS,
    parameter int ACC_WIDTH  = FX_ACC_WIDTH,
    parameter int CNT_WIDTH  = FX_CNT_WIDTH,
    parameter int MEAN_SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] s_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [9*WIDTH-1:0]      a_flat,
    output logic [3*WIDTH-1:0]      b_flat,
    output logic [CNT_WIDTH-1:0]    path_count,
    output logic                    sat_flag,
    output logic [1:0]              fsm_state
);

    // Accumulator / output index: 0 n, 1 Ss, 2 Ss2, 3 Ss3, 4 Ss4, 5 Sy, 6 Ssy, 7 Ss2y
    localparam int NSUM = 8;

    state_t     state;
    logic [1:0] drain_cnt;
    logic       take;

    // S0
    logic signed [WIDTH-1:0] s0, y0;
    logic                    v0;
    // S1
    logic signed [WIDTH-1:0] ss, sy, s1_s, s1_y;
    logic                    sat_ss, sat_sy, v1;
    // S2
    logic signed [WIDTH-1:0] s3, s4, s2y, s2_s, s2_y, s2_ss, s2_sy;
    logic                    sat_s3, sat_s4, sat_s2y, v2;

    logic signed [ACC_WIDTH-1:0] acc    [NSUM];
    logic signed [ACC_WIDTH-1:0] addend [NSUM];
    acc_t                        nxt    [NSUM];
    trunc_t                      tr     [NSUM];
    logic        [WIDTH-1:0]     out_sum[NSUM];
    logic                        acc_sat, out_sat, mul_sat;

    assign take      = in_valid & in_ready;
    assign fsm_state = state;

    // ---------------- datapath pipeline ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0    <= '0;  y0    <= '0;  v0 <= 1'b0;
            s1_s  <= '0;  s1_y  <= '0;  v1 <= 1'b0;
            s2_s  <= '0;  s2_y  <= '0;  v2 <= 1'b0;
            s2_ss <= '0;  s2_sy <= '0;
        end else begin
            if (take) begin
                s0 <= s_in;
                y0 <= y_in;
            end
            v0    <= take;
            s1_s  <= s0;
            s1_y  <= y0;
            v1    <= v0;
            s2_s  <= s1_s;
            s2_y  <= s1_y;
            s2_ss <= ss;
            s2_sy <= sy;
            v2    <= v1;
        end
    end

    fx_mul_sat #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_ss
        (.clk(clk), .rst_n(rst_n), .a(s0), .b(s0), .p(ss), .sat(sat_ss));
    fx_mul_sat #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_sy
        (.clk(clk), .rst_n(rst_n), .a(s0), .b(y0), .p(sy), .sat(sat_sy));
    fx_mul_sat #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_s3
        (.clk(clk), .rst_n(rst_n), .a(ss), .b(s1_s), .p(s3), .sat(sat_s3));
    fx_mul_sat #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_s4
        (.clk(clk), .rst_n(rst_n), .a(ss), .b(ss), .p(s4), .sat(sat_s4));
    fx_mul_sat #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_s2y
        (.clk(clk), .rst_n(rst_n), .a(ss), .b(s1_y), .p(s2y), .sat(sat_s2y));

    always_comb begin
        addend[0] = sext(ONE);
        addend[1] = sext(s2_s);
        addend[2] = sext(s2_ss);
        addend[3] = sext(s3);
        addend[4] = sext(s4);
        addend[5] = sext(s2_y);
        addend[6] = sext(s2_sy);
        addend[7] = sext(s2y);
        acc_sat   = 1'b0;
        out_sat   = 1'b0;
        for (int k = 0; k < NSUM; k++) begin
            nxt[k]  = sat_add(acc[k], addend[k]);
            tr[k]   = sat_trunc(acc[k] >>> MEAN_SHIFT);
            acc_sat = acc_sat | nxt[k].sat;
            out_sat = out_sat | tr[k].sat;
        end
        // Product saturation bits are meaningful only alongside a valid sample.
        mul_sat = (v1 & (sat_ss | sat_sy)) | (v2 & (sat_s3 | sat_s4 | sat_s2y));
    end

    // ---------------- control FSM, accumulators, outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            drain_cnt  <= 2'd0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            path_count <= '0;
            sat_flag   <= 1'b0;
            for (int k = 0; k < NSUM; k++) begin
                acc[k]     <= '0;
                out_sum[k] <= '0;
            end
        end else begin
            if (mul_sat || (v2 && acc_sat)) sat_flag <= 1'b1;
            if (v2) begin
                for (int k = 0; k < NSUM; k++) acc[k] <= nxt[k].value;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NSUM; k++) acc[k] <= '0;
                        path_count <= '0;
                        sat_flag   <= 1'b0;
                        in_ready   <= 1'b1;
                        state      <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (take) begin
                        if (path_count == '1) sat_flag <= 1'b1;
                        else                  path_count <= path_count + CNT_WIDTH'(1);
                        if (in_last) begin
                            in_ready  <= 1'b0;
                            drain_cnt <= 2'd0;
                            state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Four cycles cover S0..S3 so the last sample has been summed.
                    if (drain_cnt == 2'd3) begin
                        for (int k = 0; k < NSUM; k++) out_sum[k] <= tr[k].value;
                        if (out_sat) sat_flag <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= ST_OUTPUT;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Symmetric entries of A share the same moment register.
    assign a_flat = {out_sum[4], out_sum[3], out_sum[2],
                     out_sum[3], out_sum[2], out_sum[1],
                     out_sum[2], out_sum[1], out_sum[0]};
    assign b_flat = {out_sum[7], out_sum[6], out_sum[5]};

endmodule
